// File: rtl/pwm_pkg.sv
// Shared widths, reset defaults and ramp state codes for the PWM duty-ramp controller.
package pwm_pkg;

  localparam int DUTY_W = 4;
  localparam int RAMP_W = 8;

  localparam logic [DUTY_W-1:0] DUTY_MAX_DEF   = 4'd10;
  localparam logic [DUTY_W-1:0] DUTY_RESET_DEF = 4'd5;

  typedef logic [1:0] ramp_state_t;

  localparam ramp_state_t ST_HOLD = 2'd0;
  localparam ramp_state_t ST_UP   = 2'd1;
  localparam ramp_state_t ST_DOWN = 2'd2;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] val,
                                                   input logic [DUTY_W-1:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// User-input and PWM-core signals of the duty-ramp controller; slave is the controller side.
interface pwm_duty_ramp_ctrl_if;
  import pwm_pkg::*;

  logic              inc_req;
  logic              dec_req;
  logic              preset_valid;
  logic [DUTY_W-1:0] preset_duty;
  logic              preset_ready;
  logic              period_end;
  logic [DUTY_W-1:0] duty_out;
  logic [DUTY_W-1:0] target_out;
  logic              busy;

  modport master (
    output inc_req, dec_req, preset_valid, preset_duty, period_end,
    input  preset_ready, duty_out, target_out, busy
  );

  modport slave (
    input  inc_req, dec_req, preset_valid, preset_duty, period_end,
    output preset_ready, duty_out, target_out, busy
  );

endinterface

// File: rtl/button_debounce.sv
// Bouncy button to single-cycle press pulse: 2-flop synchroniser, then two samples taken on the shared tick.
module button_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic tick_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic s1_q;
  logic s2_q;

  // synchroniser runs every enabled cycle, sampler stages only advance on tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else if (ena) begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (tick_i) begin
        s1_q <= sync2_q;
        s2_q <= s1_q;
      end
    end
  end

  assign pulse_o = s1_q & ~s2_q & tick_i;

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Owns the PWM duty register: buttons/preset set a target, duty slews toward it one step per RAMP_PERIODS periods.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_MAX     = 10,
  parameter int DUTY_RESET   = 5,
  parameter int DEB_DIV      = 4,
  parameter int RAMP_PERIODS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  pwm_duty_ramp_ctrl_if.slave  pif
);

  localparam int TICK_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  localparam logic [DUTY_W-1:0] DMAX      = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DRST      = DUTY_W'(DUTY_RESET);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEB_DIV - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  ramp_state_t       state_q, state_d;
  logic              tick_s;
  logic              inc_pulse_s;
  logic              dec_pulse_s;
  logic              preset_acc_s;
  logic              step_s;

  assign tick_s       = ena & (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d   = (tick_cnt_q == TICK_LAST) ? {TICK_W{1'b0}} : tick_cnt_q + TICK_W'(1);
  assign preset_acc_s = pif.preset_valid & ena;

  button_debounce u_inc_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .tick_i (tick_s),
    .btn_i  (pif.inc_req),
    .pulse_o(inc_pulse_s)
  );

  button_debounce u_dec_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .tick_i (tick_s),
    .btn_i  (pif.dec_req),
    .pulse_o(dec_pulse_s)
  );

  // target selection: preset beats buttons, opposing presses cancel, saturate before arithmetic
  always_comb begin
    target_d = target_q;
    if (preset_acc_s) begin
      target_d = clamp_duty(pif.preset_duty, DMAX);
    end else if (inc_pulse_s && dec_pulse_s) begin
      target_d = target_q;
    end else if (inc_pulse_s) begin
      target_d = (target_q >= DMAX) ? DMAX : target_q + DUTY_W'(1);
    end else if (dec_pulse_s) begin
      target_d = (target_q == {DUTY_W{1'b0}}) ? {DUTY_W{1'b0}} : target_q - DUTY_W'(1);
    end else begin
      target_d = target_q;
    end
  end

  // direction follows the live target, so a crossing reverses without passing through HOLD
  always_comb begin
    if (target_q > duty_q) begin
      state_d = ST_UP;
    end else if (target_q < duty_q) begin
      state_d = ST_DOWN;
    end else begin
      state_d = ST_HOLD;
    end
  end

  assign step_s = pif.period_end & (duty_q != target_q);

  // ramp counter and duty stepping; the guard on step_s stops overshoot in the cycle before HOLD
  always_comb begin
    duty_d = duty_q;
    ramp_d = ramp_q;
    case (state_q)
      ST_HOLD: begin
        if (state_d != ST_HOLD) begin
          ramp_d = {RAMP_W{1'b0}};
        end else begin
          ramp_d = ramp_q;
        end
      end
      ST_UP, ST_DOWN: begin
        if (step_s && (ramp_q == RAMP_LAST)) begin
          ramp_d = {RAMP_W{1'b0}};
          duty_d = (target_q > duty_q) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
        end else if (step_s) begin
          ramp_d = ramp_q + RAMP_W'(1);
        end else begin
          ramp_d = ramp_q;
        end
      end
      default: begin
        duty_d = duty_q;
        ramp_d = {RAMP_W{1'b0}};
      end
    endcase
  end

  // state registers; ena low freezes everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= {TICK_W{1'b0}};
      target_q   <= DRST;
      duty_q     <= DRST;
      ramp_q     <= {RAMP_W{1'b0}};
      state_q    <= ST_HOLD;
    end else if (ena) begin
      tick_cnt_q <= tick_cnt_d;
      target_q   <= target_d;
      duty_q     <= duty_d;
      ramp_q     <= ramp_d;
      state_q    <= state_d;
    end
  end

  assign pif.duty_out     = duty_q;
  assign pif.target_out   = target_q;
  assign pif.busy         = (duty_q != target_q);
  assign pif.preset_ready = ena;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed scenarios plus a randomized soak of the duty-ramp controller against a queue-based reference model.
module tb_pwm_duty_ramp_ctrl;

  localparam int DEB_DIV      = 4;
  localparam int RAMP_PERIODS = 2;
  localparam int DMAX         = 10;
  localparam int DRST         = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  pwm_duty_ramp_ctrl_if pif();

  pwm_duty_ramp_ctrl #(
    .DUTY_MAX    (DMAX),
    .DUTY_RESET  (DRST),
    .DEB_DIV     (DEB_DIV),
    .RAMP_PERIODS(RAMP_PERIODS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .pif  (pif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pe_cnt   = 0;
  bit pe_rand  = 1'b0;

  // reference model state
  int m_duty;
  int m_target;
  int m_ramp;
  bit m_moving;
  int m_n;
  bit m_hist[2][$];
  bit m_samp[2][$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return (m_n % DEB_DIV) == (DEB_DIV - 1);
  endfunction

  // pulse the model predicts for button b at the coming edge (assuming ena)
  function automatic bit m_pulse(input int b);
    int sz;
    sz = m_samp[b].size();
    return m_tick() && m_samp[b][sz-1] && !m_samp[b][sz-2];
  endfunction

  task automatic model_reset();
    m_duty   = DRST;
    m_target = DRST;
    m_ramp   = 0;
    m_moving = 1'b0;
    m_n      = 0;
    for (int b = 0; b < 2; b++) begin
      m_hist[b].delete();
      m_samp[b].delete();
      m_hist[b].push_back(1'b0);
      m_hist[b].push_back(1'b0);
      m_samp[b].push_back(1'b0);
      m_samp[b].push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit pul[2];
    bit raw[2];
    bit tk;
    bit nm;
    int nt;
    int sz;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ena) return;
    tk     = m_tick();
    raw[0] = pif.inc_req;
    raw[1] = pif.dec_req;
    pul[0] = m_pulse(0);
    pul[1] = m_pulse(1);
    nt = m_target;
    if (pif.preset_valid) nt = (int'(pif.preset_duty) > DMAX) ? DMAX : int'(pif.preset_duty);
    else if (pul[0] && pul[1]) nt = m_target;
    else if (pul[0]) nt = (m_target >= DMAX) ? DMAX : m_target + 1;
    else if (pul[1]) nt = (m_target <= 0) ? 0 : m_target - 1;
    nm = (m_target != m_duty);
    if (m_moving) begin
      if (pif.period_end && (m_duty != m_target)) begin
        if (m_ramp == RAMP_PERIODS - 1) begin
          m_ramp = 0;
          m_duty = (m_target > m_duty) ? m_duty + 1 : m_duty - 1;
        end else begin
          m_ramp++;
        end
      end
    end else if (nm) begin
      m_ramp = 0;
    end
    for (int b = 0; b < 2; b++) begin
      sz = m_hist[b].size();
      if (tk) m_samp[b].push_back(m_hist[b][sz-2]);
      m_hist[b].push_back(raw[b]);
      if (m_hist[b].size() > 4) void'(m_hist[b].pop_front());
      if (m_samp[b].size() > 4) void'(m_samp[b].pop_front());
    end
    m_n++;
    m_target = nt;
    m_moving = nm;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("duty", pif.duty_out, m_duty);
    check_val("target", pif.target_out, m_target);
    check_val("busy", pif.busy, (m_duty != m_target));
    check_val("ready", pif.preset_ready, ena);
    if (m_duty > DMAX || m_duty < 0) check_val("duty_range", m_duty, DMAX);
    pe_cnt++;
    pif.period_end = pe_rand ? ($urandom_range(0, 5) == 0) : ((pe_cnt % 10) == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_duty(input string tag, input int val, input int budget);
    for (int i = 0; i < budget && m_duty != val; i++) step();
    check_val(tag, pif.duty_out, val);
  endtask

  task automatic do_preset(input int val);
    pif.preset_valid = 1'b1;
    pif.preset_duty  = 4'(val);
    step();
    pif.preset_valid = 1'b0;
  endtask

  initial begin
    bit found;
    bit lvl[2];
    int bounce[2];
    pif.inc_req      = 1'b0;
    pif.dec_req      = 1'b0;
    pif.preset_valid = 1'b0;
    pif.preset_duty  = 4'd0;
    pif.period_end   = 1'b0;
    model_reset();
    ena   = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check_val("rst_duty", pif.duty_out, DRST);
    check_val("rst_target", pif.target_out, DRST);
    check_val("rst_busy", pif.busy, 0);

    // idle after reset
    repeat (200) step();
    check_val("idle_duty", pif.duty_out, DRST);

    // one long press gives exactly one increment
    pif.inc_req = 1'b1;
    repeat (40) step();
    pif.inc_req = 1'b0;
    check_val("inc_target", pif.target_out, 6);
    wait_duty("inc_duty", 6, 100);
    step();
    check_val("inc_busy", pif.busy, 0);

    // preset to full scale ramps from reset value
    do_reset();
    do_preset(10);
    check_val("p10_target", pif.target_out, 10);
    check_val("p10_busy", pif.busy, 1);
    wait_duty("p10_duty", 10, 300);
    step();
    check_val("p10_hold", pif.busy, 0);

    // clamp, then reversal mid-ramp
    do_reset();
    do_preset(14);
    check_val("clamp", pif.target_out, 10);
    wait_duty("mid7", 7, 200);
    do_preset(0);
    check_val("p0_target", pif.target_out, 0);
    wait_duty("down0", 0, 400);

    // opposing presses cancel
    do_reset();
    pif.inc_req = 1'b1;
    pif.dec_req = 1'b1;
    repeat (30) step();
    pif.inc_req = 1'b0;
    pif.dec_req = 1'b0;
    repeat (30) step();
    check_val("both_target", pif.target_out, DRST);

    // preset in the same cycle as an inc pulse wins
    pif.inc_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_pulse(0)) begin
        found = 1'b1;
        do_preset(3);
      end else begin
        step();
      end
    end
    check_val("coinc_found", found, 1);
    check_val("coinc_target", pif.target_out, 3);
    pif.inc_req = 1'b0;
    repeat (30) step();
    check_val("coinc_after", pif.target_out, 3);

    // freeze mid-ramp, ignoring presets, then resume and reset mid-ramp
    do_reset();
    do_preset(10);
    wait_duty("frz_pre", 7, 200);
    ena = 1'b0;
    pif.preset_valid = 1'b1;
    pif.preset_duty  = 4'd0;
    repeat (50) step();
    pif.preset_valid = 1'b0;
    check_val("frz_duty", pif.duty_out, 7);
    check_val("frz_target", pif.target_out, 10);
    ena = 1'b1;
    wait_duty("resume", 8, 100);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_val("mid_rst_duty", pif.duty_out, DRST);
    check_val("mid_rst_target", pif.target_out, DRST);

    // randomized soak with bouncy buttons
    pe_rand   = 1'b1;
    lvl[0]    = 1'b0;
    lvl[1]    = 1'b0;
    bounce[0] = 0;
    bounce[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 39) == 0) begin
          lvl[b]    = ~lvl[b];
          bounce[b] = $urandom_range(0, 6);
        end
        if (bounce[b] > 0) bounce[b]--;
      end
      pif.inc_req      = lvl[0] ^ ((bounce[0] > 0) && ($urandom_range(0, 1) == 1));
      pif.dec_req      = lvl[1] ^ ((bounce[1] > 0) && ($urandom_range(0, 1) == 1));
      pif.preset_valid = ($urandom_range(0, 59) == 0);
      pif.preset_duty  = 4'($urandom_range(0, 15));
      ena              = ($urandom_range(0, 19) != 0);
      rst_n            = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
